smp_ctrl_hub: RTL and testbench

//  Avalon-MM slave that fronts the per-core SMP control elements. Decodes host writes into
//  per-core byte commands and registered write strobes, gathers per-core status into one

---
 rtl/smp_ctrl_hub_if.sv | 18 +
 rtl/smp_ctrl_hub.sv | 76 +++++++
 tb/tb_smp_ctrl_hub.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/smp_ctrl_hub_if.sv
// smp_ctrl_hub_if: Avalon-MM host bus between the interconnect and smp_ctrl_hub.
interface smp_ctrl_hub_if;
  logic [1:0]  avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  modport master (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_readdata, avl_readdatavalid
  );
  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_readdata, avl_readdatavalid
  );
endinterface

// File: rtl/smp_ctrl_hub.sv
// smp_ctrl_hub: Avalon-MM front end for per-core SMP control elements (commands, status, sticky events, irq).
// Optional macro SMP_HALT_ALL_ON_BREAK_EN: a breakpoint on one core halts all other cores.
module smp_ctrl_hub #(
  parameter int NUM_CORES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  smp_ctrl_hub_if.slave          avl,
  output logic [NUM_CORES-1:0]   o_pe_write,
  output logic [8*NUM_CORES-1:0] o_pe_writedata,
  input  logic [8*NUM_CORES-1:0] i_pe_readdata,
  output logic                   o_irq
);
  logic [NUM_CORES-1:0]   r_prev_bp, r_prev_halt, r_pe_write;
  logic [NUM_CORES-1:0]   w_bp, w_halt, w_bp_rise, w_halt_rise, w_lane_wr, w_auto;
  logic [8*NUM_CORES-1:0] r_pe_wd, w_pe_wd;
  logic [15:0]            r_events, r_mask, w_set, w_clr, w_be16, w_mask_nx;
  logic [31:0]            r_rdata, w_rdata;
  logic                   r_rdv, r_irq, w_ctrl_wr;

  assign w_ctrl_wr   = avl.avl_write && avl.avl_address == 2'd0;
  assign w_lane_wr   = avl.avl_byteenable[NUM_CORES-1:0] & {NUM_CORES{w_ctrl_wr}};
  assign w_bp_rise   = w_bp & ~r_prev_bp;
  assign w_halt_rise = w_halt & ~r_prev_halt;
  assign w_set       = {8'(w_halt_rise), 8'(w_bp_rise)};
  assign w_be16      = {{8{avl.avl_byteenable[1]}}, {8{avl.avl_byteenable[0]}}};
  assign w_clr       = (avl.avl_write && avl.avl_address == 2'd1) ? avl.avl_writedata[15:0] & w_be16 : 16'h0;
  assign w_mask_nx   = (avl.avl_write && avl.avl_address == 2'd2) ?
                       (avl.avl_writedata[15:0] & w_be16) | (r_mask & ~w_be16) : r_mask;
  assign w_rdata     = avl.avl_address == 2'd0 ? 32'(i_pe_readdata) :
                       avl.avl_address == 2'd1 ? {16'h0, r_events} :
                       avl.avl_address == 2'd2 ? {16'h0, r_mask} : 32'h0;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign w_bp[i]   = i_pe_readdata[8*i+1];
    assign w_halt[i] = i_pe_readdata[8*i];
`ifdef SMP_HALT_ALL_ON_BREAK_EN
    // A core never halts itself for its own breakpoint, but any other breaker halts it.
    assign w_auto[i] = |(w_bp_rise & ~(NUM_CORES'(1) << i));
`else
    assign w_auto[i] = 1'b0;
`endif
    assign w_pe_wd[8*i +: 8] = w_lane_wr[i] ? avl.avl_writedata[8*i +: 8] :
                               w_auto[i]    ? 8'h02 : r_pe_wd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_bp   <= '0;
      r_prev_halt <= '0;
      r_events    <= '0;
      r_mask      <= '0;
      r_irq       <= 1'b0;
      r_pe_write  <= '0;
      r_pe_wd     <= '0;
      r_rdv       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_prev_bp   <= w_bp;
      r_prev_halt <= w_halt;
      r_events    <= (r_events & ~w_clr) | w_set;
      r_mask      <= w_mask_nx;
      r_irq       <= |(r_events & r_mask);
      r_pe_write  <= w_lane_wr | w_auto;
      r_pe_wd     <= w_pe_wd;
      r_rdv       <= avl.avl_read;
      r_rdata     <= avl.avl_read ? w_rdata : r_rdata;
    end
  end

  assign avl.avl_readdata      = r_rdata;
  assign avl.avl_readdatavalid = r_rdv;
  assign o_pe_write            = r_pe_write;
  assign o_pe_writedata        = r_pe_wd;
  assign o_irq                 = r_irq;
endmodule

// File: tb/tb_smp_ctrl_hub.sv
// tb_smp_ctrl_hub: directed checks of smp_ctrl_hub with 4 cores and a 2-core instance.
module tb_smp_ctrl_hub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pe_write;
  logic [31:0] pe_wd, pe_rd;
  logic        irq;
  logic [1:0]  pe_write2;
  logic [15:0] pe_wd2, pe_rd2;
  logic        irq2;
  int          n_vec = 0;
  int          n_err = 0;

  smp_ctrl_hub_if bus ();
  smp_ctrl_hub_if bus2 ();

  smp_ctrl_hub #(.NUM_CORES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .avl(bus.slave),
    .o_pe_write(pe_write), .o_pe_writedata(pe_wd), .i_pe_readdata(pe_rd), .o_irq(irq)
  );
  smp_ctrl_hub #(.NUM_CORES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .avl(bus2.slave),
    .o_pe_write(pe_write2), .o_pe_writedata(pe_wd2), .i_pe_readdata(pe_rd2), .o_irq(irq2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_set(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.avl_read = rd; bus.avl_write = wr; bus.avl_address = a;
    bus.avl_writedata = d; bus.avl_byteenable = be;
  endtask

  initial begin
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    bus2.avl_read = 0; bus2.avl_write = 0; bus2.avl_address = 0;
    bus2.avl_writedata = 0; bus2.avl_byteenable = 0;
    pe_rd = 32'h0; pe_rd2 = 16'h0;
    tick(); tick();
    chk("rst_rdv", 32'(bus.avl_readdatavalid), 32'h0);
    chk("rst_rdata", bus.avl_readdata, 32'h0);
    chk("rst_pe_write", 32'(pe_write), 32'h0);
    chk("rst_pe_wd", pe_wd, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    tick();
    // host command to cores 0 and 1
    bus_set(0, 1, 2'd0, 32'h0000_0201, 4'h3);
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    chk("ctrl_wr_strobe", 32'(pe_write), 32'h3);
    chk("ctrl_wr_data", pe_wd, 32'h0000_0201);
    tick();
    chk("ctrl_strobe_drop", 32'(pe_write), 32'h0);
    chk("ctrl_data_hold", pe_wd, 32'h0000_0201);
    // status read; bp rises on cores 0,2 and halt rises on cores 1,2
    pe_rd = 32'h0003_0102;
    bus_set(1, 0, 2'd0, 32'h0, 4'h0);
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    chk("status_rdv", 32'(bus.avl_readdatavalid), 32'h1);
    chk("status_rdata", bus.avl_readdata, 32'h0003_0102);
`ifdef SMP_HALT_ALL_ON_BREAK_EN
    chk("multi_break_halt_all", 32'(pe_write), 32'hF);
    chk("multi_break_halt_data", pe_wd, 32'h0202_0202);
`else
    chk("break_no_strobe", 32'(pe_write), 32'h0);
`endif
    tick();
    chk("rdv_one_cycle", 32'(bus.avl_readdatavalid), 32'h0);
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("events_multi", bus.avl_readdata, 32'h0000_0605);
    bus_set(0, 1, 2'd1, 32'h0000_FFFF, 4'h3);
    tick();
    pe_rd = 32'h0;
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("events_w1c_all", bus.avl_readdata, 32'h0);
    // core2 breakpoint alone, masked off
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    pe_rd = 32'h0002_0000;
    tick();
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("events_core2_bp", bus.avl_readdata, 32'h0000_0004);
    chk("irq_masked", 32'(irq), 32'h0);
    bus_set(0, 1, 2'd2, 32'h0000_0004, 4'h3);
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    chk("irq_one_cycle_late", 32'(irq), 32'h0);
    tick();
    chk("irq_asserted", 32'(irq), 32'h1);
    bus_set(0, 1, 2'd1, 32'h0000_0004, 4'h1);
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    chk("irq_after_clear_edge", 32'(irq), 32'h1);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("events_after_w1c", bus.avl_readdata, 32'h0);
    // halt rise on core1 collides with W1C of bit 9
    pe_rd = 32'h0002_0100;
    bus_set(0, 1, 2'd1, 32'h0000_0200, 4'h2);
    tick();
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("set_wins_over_clear", bus.avl_readdata, 32'h0000_0200);
    // core0 breaks while host commands lane 3
    pe_rd = 32'h0002_0102;
    bus_set(0, 1, 2'd0, 32'h0100_0000, 4'h8);
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
`ifdef SMP_HALT_ALL_ON_BREAK_EN
    chk("halt_all_strobe", 32'(pe_write), 32'hE);
    chk("halt_all_data", pe_wd, 32'h0102_0202);
`else
    chk("host_only_strobe", 32'(pe_write), 32'h8);
    chk("host_only_data", pe_wd, 32'h0100_0201);
`endif
    tick();
    chk("strobe_drop2", 32'(pe_write), 32'h0);
    // simultaneous read and write returns the pre-write value
    bus_set(1, 1, 2'd2, 32'h0000_00FF, 4'h3);
    tick();
    chk("rw_collision_old", bus.avl_readdata, 32'h0000_0004);
    bus_set(1, 0, 2'd2, 32'h0, 4'h0);
    tick();
    chk("mask_readback", bus.avl_readdata, 32'h0000_00FF);
    chk("irq_from_bit0", 32'(irq), 32'h1);
    bus_set(0, 1, 2'd2, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus_set(1, 0, 2'd2, 32'h0, 4'h0);
    tick();
    chk("mask_upper_zero", bus.avl_readdata, 32'h0000_FFFF);
    bus_set(0, 1, 2'd3, 32'hFFFF_FFFF, 4'hF);
    tick();
    chk("reserved_no_strobe", 32'(pe_write), 32'h0);
    bus_set(1, 0, 2'd3, 32'h0, 4'h0);
    tick();
    chk("reserved_reads_0", bus.avl_readdata, 32'h0);
    bus_set(1, 0, 2'd1, 32'h0, 4'h0);
    tick();
    chk("events_upper_zero", bus.avl_readdata, 32'h0000_0201);
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    // two-core instance ignores lanes 2 and 3
    bus2.avl_write = 1; bus2.avl_address = 2'd0;
    bus2.avl_writedata = 32'h0404_0404; bus2.avl_byteenable = 4'hF;
    tick();
    bus2.avl_write = 0; bus2.avl_byteenable = 4'h0;
    chk("nc2_strobe", 32'(pe_write2), 32'h3);
    chk("nc2_data", 32'(pe_wd2), 32'h0000_0404);
    pe_rd2 = 16'h0102;
    bus2.avl_read = 1;
    tick();
    bus2.avl_read = 0;
    chk("nc2_status", bus2.avl_readdata, 32'h0000_0102);
    // reset mid-operation drops pending strobe and readdatavalid
    bus_set(1, 1, 2'd0, 32'h0000_00FF, 4'hF);
    #2 rst_n = 1'b0;
    tick();
    bus_set(0, 0, 2'd0, 32'h0, 4'h0);
    chk("midrst_strobe", 32'(pe_write), 32'h0);
    chk("midrst_rdv", 32'(bus.avl_readdatavalid), 32'h0);
    chk("midrst_data", pe_wd, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_strobe", 32'(pe_write), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
